// File: rtl/ws2812_tx_pkg.sv
// Shared definitions for the WS2812 transmitter: nominal timing, FSM encoding and
// wire-order helper. Optional macro: WS2812_TX_GRB_EN selects GRB wire order.
package ws2812_tx_pkg;

  // Nominal line timing in nanoseconds; cycle counts are module parameters.
  localparam int T0H_NS  = 400;
  localparam int T1H_NS  = 800;
  localparam int TBIT_NS = 1240;
  localparam int RET_NS  = 52000;
  localparam int RET_MIN_NS = 50000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT  = 2'd1,
    RET  = 2'd2
  } tx_state_t;

  // Reorders a presented {R,G,B} word into the order it leaves on the wire.
  function automatic logic [23:0] wire_order(input logic [23:0] rgb);
`ifdef WS2812_TX_GRB_EN
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
`else
    return rgb;
`endif
  endfunction

endpackage

// File: rtl/ws2812_tx_bit_timer.sv
// Cycle counter shared by bit periods and the latch period, with the terminal
// compares and the high/low decision for the bit currently on the line.
module ws2812_bit_timer #(
  parameter int T0H_CYC  = 20,
  parameter int T1H_CYC  = 40,
  parameter int TBIT_CYC = 62,
  parameter int RET_CYC  = 2600
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_bit_val,
  output logic o_first,
  output logic o_bit_end,
  output logic o_ret_end,
  output logic o_high
);

  localparam int CW = $clog2(RET_CYC + 1);
  localparam logic [CW-1:0] T0H_C     = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_C     = CW'(T1H_CYC);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] RET_LAST  = CW'(RET_CYC - 1);

  if (!(T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && RET_CYC >= TBIT_CYC)) begin : g_param_err
    $error("ws2812_bit_timer: need T0H_CYC < T1H_CYC < TBIT_CYC and RET_CYC >= TBIT_CYC");
  end

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else if (i_clear) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign o_first   = (cnt_reg == '0);
  assign o_bit_end = (cnt_reg == TBIT_LAST);
  assign o_ret_end = (cnt_reg == RET_LAST);
  assign o_high    = (cnt_reg < (i_bit_val ? T1H_C : T0H_C));

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 serial transmitter: valid/ready word intake, MSB-first pulse-width line
// coding and frame latch period. Optional macro: WS2812_TX_GRB_EN (GRB wire order).
module ws2812_tx
  import ws2812_tx_pkg::*;
#(
  parameter int T0H_CYC  = 20,
  parameter int T1H_CYC  = 40,
  parameter int TBIT_CYC = 62,
  parameter int RET_CYC  = 2600
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_serial,
  output logic        o_busy,
  output logic        o_underrun
);

  tx_state_t   state_reg, state_next;
  logic [23:0] shift_reg, shift_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic        last_reg, last_next;
  logic        serial_reg, underrun_reg;

  logic timer_clear, accept;
  logic cnt_first, bit_end, ret_end, line_high;

  ws2812_bit_timer #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC),
    .RET_CYC  (RET_CYC)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (timer_clear),
    .i_bit_val (shift_reg[23]),
    .o_first   (cnt_first),
    .o_bit_end (bit_end),
    .o_ret_end (ret_end),
    .o_high    (line_high)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    last_next    = last_reg;
    o_ready      = 1'b0;
    accept       = 1'b0;
    timer_clear  = 1'b0;
    case (state_reg)
      IDLE: begin
        o_ready     = 1'b1;
        timer_clear = 1'b1;
        if (i_valid) begin
          accept     = 1'b1;
          state_next = BIT;
        end
      end
      BIT: begin
        if (bit_end) begin
          timer_clear = 1'b1;
          if (bit_cnt_reg != 5'd0) begin
            shift_next   = {shift_reg[22:0], 1'b0};
            bit_cnt_next = bit_cnt_reg - 5'd1;
          end else if (last_reg) begin
            state_next = RET;
          end else begin
            // Single-cycle window to chain the next word without a gap.
            o_ready = 1'b1;
            if (i_valid) begin
              accept = 1'b1;
            end else begin
              state_next = RET;
            end
          end
        end
      end
      RET: begin
        if (ret_end) begin
          timer_clear = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (accept) begin
      shift_next   = wire_order(i_data);
      bit_cnt_next = 5'd23;
      last_next    = i_last;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      last_reg     <= 1'b0;
      serial_reg   <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      last_reg    <= last_next;
      serial_reg  <= (state_reg == BIT) && line_high;
      // Registered alongside the line so the pulse aligns with the first low RET cycle on the wire.
      underrun_reg <= (state_reg == RET) && cnt_first && !last_reg;
    end
  end

  assign o_serial   = serial_reg;
  assign o_underrun = underrun_reg;
  assign o_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: a line decoder recovers words from o_serial and
// compares them with a scoreboard filled at each accepted handshake.
module tb_ws2812_tx;

  localparam int T0H  = 20;
  localparam int T1H  = 40;
  localparam int TBIT = 62;
  localparam int RETC = 2600;
  localparam int WORD_CYC = 24 * TBIT;

  logic        i_clk;
  logic        i_rst_n;
  logic [23:0] i_data;
  logic        i_valid;
  logic        i_last;
  logic        o_ready;
  logic        o_serial;
  logic        o_busy;
  logic        o_underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int underrun_pulses = 0;
  logic [23:0] sb[$];

  ws2812_tx dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_serial   (o_serial),
    .o_busy     (o_busy),
    .o_underrun (o_underrun)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] expect_wire(input logic [23:0] d);
`ifdef WS2812_TX_GRB_EN
    return {d[15:8], d[23:16], d[7:0]};
`else
    return d;
`endif
  endfunction

  // Line decoder: classifies each high pulse, checks the following low fills the bit period.
  int hi_cnt = 0, lo_cnt = 0, prev_hi = 0, nbits = 0;
  logic [23:0] rx_word = '0;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hi_cnt = 0; lo_cnt = 0; prev_hi = 0; nbits = 0;
    end else begin
      if (o_underrun) underrun_pulses++;
      if (o_serial) begin
        if (hi_cnt == 0 && prev_hi != 0 && lo_cnt < 200)
          check("bit_low_time", lo_cnt, TBIT - prev_hi);
        if (hi_cnt == 0) lo_cnt = 0;
        hi_cnt++;
      end else begin
        if (hi_cnt != 0) begin
          if (hi_cnt != T0H && hi_cnt != T1H) check("bit_high_time", hi_cnt, T1H);
          rx_word = {rx_word[22:0], (hi_cnt == T1H)};
          nbits++;
          prev_hi = hi_cnt;
          hi_cnt = 0;
          lo_cnt = 0;
          if (nbits == 24) begin
            nbits = 0;
            if (sb.size() == 0) check("unexpected_word", rx_word, 24'h0);
            else begin
              logic [23:0] exp_w;
              exp_w = sb.pop_front();
              check("rx_word", rx_word, exp_w);
              $display("word rx=%06h exp=%06h", rx_word, exp_w);
            end
          end
        end
        lo_cnt++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with i_valid still high.
  task automatic send(input logic [23:0] d, input logic l, input bit push, output int acc_cyc);
    int n;
    i_data = d; i_last = l; i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 20000) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) check("accept_timeout", 0, 1);
    if (push) sb.push_back(expect_wire(d));
    @(negedge i_clk);
    acc_cyc = cyc;
    $display("send data=%06h last=%0b accepted_cycle=%0d", d, l, acc_cyc);
  endtask

  task automatic wait_idle(output int end_cyc);
    int n;
    n = 0;
    while (o_busy && n < 20000) begin
      @(negedge i_clk);
      n++;
    end
    if (o_busy) check("idle_timeout", 0, 1);
    end_cyc = cyc;
  endtask

  initial begin
    int acc, acc2, done, n, rise_cyc, ur_cyc;
    bit saw_high, saw_ready;
    i_rst_n = 1'b0; i_data = '0; i_valid = 1'b0; i_last = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_serial", o_serial, 0);
    check("rst_busy", o_busy, 0);
    check("rst_underrun", o_underrun, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_ready", o_ready, 1);

    // Single word, line rises one edge after acceptance.
    send(24'hFF00FF, 1'b1, 1, acc);
    i_valid = 1'b0;
    check("single_first_low", o_serial, 0);
    @(negedge i_clk);
    check("single_rise", o_serial, 1);
    wait_idle(done);
    check("single_busy_len", done - acc, WORD_CYC + RETC);

    // Back-to-back words with i_valid held.
    send(24'h123456, 1'b0, 1, acc);
    send(24'hABCDEF, 1'b1, 1, acc2);
    i_valid = 1'b0;
    check("b2b_gap", acc2 - acc, WORD_CYC);
    wait_idle(done);
    check("b2b_busy_len", done - acc, 2 * WORD_CYC + RETC);

    // Underrun: no follow-up word after a non-last word.
    send(24'h0000FF, 1'b0, 1, acc);
    i_valid = 1'b0;
    n = 0;
    while (!o_serial && n < 100) begin @(negedge i_clk); n++; end
    rise_cyc = cyc;
    n = 0;
    while (!o_underrun && n < 4000) begin @(negedge i_clk); n++; end
    ur_cyc = cyc;
    check("underrun_time", ur_cyc - rise_cyc, WORD_CYC);
    @(negedge i_clk);
    check("underrun_width", o_underrun, 0);
    saw_high = 1'b0;
    saw_ready = 1'b0;
    n = 0;
    while (!o_ready && n < 4000) begin
      if (o_serial) saw_high = 1'b1;
      @(negedge i_clk);
      n++;
    end
    check("underrun_ret_low", saw_high, 0);
    check("underrun_ready_time", cyc - acc, WORD_CYC + RETC);
    check("underrun_count", underrun_pulses, 1);

    // Handshake stall: valid during RET with changing data; only the accepting edge counts.
    send(24'h00FF00, 1'b1, 1, acc);
    repeat (WORD_CYC + 10) @(negedge i_clk);
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 4000) begin
      i_data = 24'($urandom);
      @(negedge i_clk);
      n++;
    end
    check("stall_ready_time", cyc - acc, WORD_CYC + RETC);
    check("stall_accept_idle", o_busy, 0);
    send(24'h5AC33C, 1'b1, 1, acc2);
    i_valid = 1'b0;
    repeat (100) begin
      i_data = 24'($urandom);
      @(negedge i_clk);
    end
    wait_idle(done);

    // Colour-order word.
    send(24'h112233, 1'b1, 1, acc);
    i_valid = 1'b0;
    wait_idle(done);
    check("rgb_busy_len", done - acc, WORD_CYC + RETC);

    // Asynchronous reset during bit 10 (14th bit on the line), in its high phase.
    send(24'hFFFFFF, 1'b1, 0, acc);
    i_valid = 1'b0;
    repeat (13 * TBIT + 4) @(negedge i_clk);
    check("mid_frame_high", o_serial, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_serial", o_serial, 0);
    check("async_rst_busy", o_busy, 0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_busy", o_busy, 0);
    check("post_rst_ready", o_ready, 1);
    repeat (200) @(negedge i_clk);
    check("post_rst_line", o_serial, 0);

    check("scoreboard_empty", sb.size(), 0);
    check("underrun_total", underrun_pulses, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
